sata_link_arbiter: RTL
======================

Name: sata_link_arbiter

Overview:
- Sequences and shares the SATA link layer between the local transmit requester (the transport layer) and remote-initiated receive frames.
- Issues write_start, tracks write and read completion, and resolves X_RDY collisions by yielding to the remote side.
- Retries failed transmissions, up to a fixed limit, after a backoff.
- Drives sync_escape when a frame stalls past a watchdog limit.
- Sits between the transport layer and sata_link_layer.

Parameters:
- MAX_RETRY, 3: transmit attempts allowed after the first failure.
- TIMEOUT, 24'd1000000: watchdog limit in clk cycles for the XMIT and RX states.
- ESCAPE_CYCLES, 4: number of cycles sync_escape is held high.
- BACKOFF_CYCLES, 8: idle cycles before a retry is issued.

Ports:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- phy_ready in 1: PHY link up.
- link_layer_ready in 1: link layer is idle.
- detect_x_rdy in 1: remote X_RDY seen.
- tx_req in 1: level request; tx_size must be stable while it is high.
- tx_size in 24: frame size in dwords.
- write_finished in 1: pulse, write completed.
- xmit_error in 1: pulse, remote rejected the frame (R_ERR).
- read_start in 1: pulse, remote frame begun.
- read_finished in 1: pulse, remote frame ended.
- write_start out 1: pulse to the link layer.
- write_size out 24: latched copy of tx_size.
- sync_escape out 1: escape request to the link layer.
- tx_grant out 1: high while our frame owns the link.
- tx_done out 1: pulse, frame sent successfully.
- tx_fail out 1: pulse, frame abandoned.
- tx_err_code out 2: 0 none, 1 retries exhausted, 2 zero size, 3 PHY lost; valid while tx_fail is high.
- rx_busy out 1: high during a remote frame.
- retry_count out 4: failures so far on the current frame.
- arb_state out 4: debug view of the state register.

Behaviour:
- Reset values: every output is 0; state is IDLE.
- All outputs are registered.
- States (4-bit encoding): IDLE=0, START=1, XMIT=2, RX=3, ESCAPE=4, BACKOFF=5, DONE=6, FAIL=7.
- IDLE
  - If !phy_ready, stay in IDLE.
  - Else if detect_x_rdy or read_start → RX. Remote has priority over a pending tx_req.
  - Else if tx_req && link_layer_ready:
    - tx_size==0 → FAIL with code 2.
    - Otherwise latch write_size, set tx_grant=1, → START.
- START: write_start=1 for exactly one cycle, then → XMIT.
- XMIT
  - Clear the watchdog counter on entry; it increments every cycle.
  - write_finished → DONE.
  - xmit_error → retry_count+1, then:
    - new count > MAX_RETRY → FAIL with code 1;
    - otherwise → BACKOFF.
  - read_start (collision lost) → RX with tx_grant=0. retry_count is unchanged; the request stays pending and is re-arbitrated from IDLE.
  - Counter reaches TIMEOUT → ESCAPE, flagged as a tx error.
  - Simultaneous events, priority: write_finished > xmit_error > read_start > timeout.
- RX
  - rx_busy=1; the watchdog is cleared on entry.
  - read_finished → IDLE.
  - TIMEOUT → ESCAPE, flagged as an rx error.
- ESCAPE
  - sync_escape=1 for ESCAPE_CYCLES cycles, then wait for link_layer_ready.
  - rx error → IDLE.
  - tx error → same retry logic as xmit_error (BACKOFF or FAIL code 1).
- BACKOFF: count BACKOFF_CYCLES, then → IDLE. The retry re-enters through IDLE, so a remote frame may still preempt it.
- DONE
  - tx_done=1 for one cycle; clear retry_count and tx_grant; → IDLE.
  - The requester drops tx_req on the edge that samples tx_done.
- FAIL: same as DONE, but pulses tx_fail with tx_err_code.
- phy_ready low in any state other than IDLE:
  - Next state IDLE; sync_escape, rx_busy and tx_grant are cleared.
  - If a tx frame was pending (START, XMIT, BACKOFF, or ESCAPE with a tx error), go through FAIL with code 3 first.
- Watchdog: 24-bit saturating counter, so it never wraps.
- retry_count: 4 bits wide; MAX_RETRY must be ≤ 14.

Decomposition:
- Add the state encodings and the tx_err_code constants to sata_defines.v.
- No sub-module is needed. The watchdog counter and the backoff counter share one 24-bit counter register, inline.

Test Plan:
- tx_req=1, tx_size=24'd16, write_finished 10 cycles after write_start → exactly one write_start, write_size=16, tx_done 1 cycle later, retry_count=0.
- tx_size=0 → tx_fail with code 2, no write_start issued.
- xmit_error on 4 consecutive attempts (MAX_RETRY=3) → 4 write_starts, each at least BACKOFF_CYCLES apart; tx_fail code 1; retry_count=4 at fail, 0 afterwards.
- tx_req and detect_x_rdy asserted in the same cycle → RX first with rx_busy=1; after read_finished, write_start issues.
- TIMEOUT=100, no write_finished → sync_escape high for 4 cycles at cycle 100; after link_layer_ready, a retry write_start follows.
- phy_ready dropped mid-XMIT → tx_fail code 3 next cycle, tx_grant=0, state IDLE.

Source files
------------

// File: rtl/sata_link_arbiter_pkg.sv
// Shared types and constants for the SATA link arbiter: state encoding,
// failure codes and the saturating counter helper.
package sata_link_arbiter_pkg;

  localparam int SIZE_W = 24;
  localparam int CNT_W  = 24;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_START   = 4'd1,
    ST_XMIT    = 4'd2,
    ST_RX      = 4'd3,
    ST_ESCAPE  = 4'd4,
    ST_BACKOFF = 4'd5,
    ST_DONE    = 4'd6,
    ST_FAIL    = 4'd7
  } arb_state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_RETRY     = 2'd1;
  localparam logic [1:0] ERR_ZERO_SIZE = 2'd2;
  localparam logic [1:0] ERR_PHY_LOST  = 2'd3;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sata_link_arbiter_if.sv
// Transport/link-layer signal bundle around the arbiter. The slave modport
// is the arbiter's view; master is the surrounding environment.
interface sata_link_arbiter_if;
  import sata_link_arbiter_pkg::*;

  logic              phy_ready;
  logic              link_layer_ready;
  logic              detect_x_rdy;
  logic              tx_req;
  logic [SIZE_W-1:0] tx_size;
  logic              write_finished;
  logic              xmit_error;
  logic              read_start;
  logic              read_finished;
  logic              write_start;
  logic [SIZE_W-1:0] write_size;
  logic              sync_escape;
  logic              tx_grant;
  logic              tx_done;
  logic              tx_fail;
  logic [1:0]        tx_err_code;
  logic              rx_busy;
  logic [3:0]        retry_count;
  logic [3:0]        arb_state;

  modport slave (
    input  phy_ready, link_layer_ready, detect_x_rdy, tx_req, tx_size,
           write_finished, xmit_error, read_start, read_finished,
    output write_start, write_size, sync_escape, tx_grant, tx_done, tx_fail,
           tx_err_code, rx_busy, retry_count, arb_state
  );

  modport master (
    output phy_ready, link_layer_ready, detect_x_rdy, tx_req, tx_size,
           write_finished, xmit_error, read_start, read_finished,
    input  write_start, write_size, sync_escape, tx_grant, tx_done, tx_fail,
           tx_err_code, rx_busy, retry_count, arb_state
  );

endinterface

// File: rtl/sata_link_arbiter.sv
// Shares the SATA link between local transmit frames and remote receive
// frames, with retry/backoff, collision yield and a stall watchdog.
module sata_link_arbiter
  import sata_link_arbiter_pkg::*;
#(
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [23:0] TIMEOUT        = 24'd1000000,
  parameter int unsigned ESCAPE_CYCLES  = 4,
  parameter int unsigned BACKOFF_CYCLES = 8
) (
  input logic                clk,
  input logic                rst,
  sata_link_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT - 24'd1;
  localparam logic [CNT_W-1:0] ESCAPE_LEN   = CNT_W'(ESCAPE_CYCLES);
  localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

  arb_state_t        state_r, state_nx;
  logic [CNT_W-1:0]  cnt_r, cnt_nx;
  logic [3:0]        retry_r, retry_nx, retry_inc;
  logic              tx_err_r, tx_err_nx;
  logic [SIZE_W-1:0] size_r, size_nx;
  logic [1:0]        err_code_r, err_code_nx;
  logic              write_start_r, sync_escape_r, tx_grant_r;
  logic              tx_done_r, tx_fail_r, rx_busy_r;
  logic              phy_loss, tx_pending;

  assign retry_inc  = retry_r + 4'd1;
  assign phy_loss   = !bus.phy_ready &&
                      (state_r inside {ST_START, ST_XMIT, ST_RX, ST_ESCAPE, ST_BACKOFF});
  // An escape raised by our own frame still counts as a pending transmit.
  assign tx_pending = (state_r inside {ST_START, ST_XMIT, ST_BACKOFF}) ||
                      (state_r == ST_ESCAPE && tx_err_r);
  // Watchdog and backoff share one counter, restarted on every state change.
  assign cnt_nx     = (state_nx != state_r) ? {CNT_W{1'b0}} : sat_inc(cnt_r);

  // Next-state, retry bookkeeping and failure code selection.
  always_comb begin
    state_nx    = state_r;
    retry_nx    = retry_r;
    tx_err_nx   = tx_err_r;
    size_nx     = size_r;
    err_code_nx = ERR_NONE;
    if (phy_loss) begin
      if (tx_pending) begin
        state_nx    = ST_FAIL;
        err_code_nx = ERR_PHY_LOST;
      end else begin
        state_nx    = ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!bus.phy_ready) begin
            state_nx = ST_IDLE;
          end else if (bus.detect_x_rdy || bus.read_start) begin
            state_nx = ST_RX;
          end else if (bus.tx_req && bus.link_layer_ready) begin
            if (bus.tx_size == {SIZE_W{1'b0}}) begin
              state_nx    = ST_FAIL;
              err_code_nx = ERR_ZERO_SIZE;
            end else begin
              state_nx = ST_START;
              size_nx  = bus.tx_size;
            end
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_START: state_nx = ST_XMIT;
        ST_XMIT: begin
          if (bus.write_finished) begin
            state_nx = ST_DONE;
          end else if (bus.xmit_error) begin
            retry_nx = retry_inc;
            if (retry_inc > RETRY_LIMIT) begin
              state_nx    = ST_FAIL;
              err_code_nx = ERR_RETRY;
            end else begin
              state_nx = ST_BACKOFF;
            end
          end else if (bus.read_start) begin
            state_nx = ST_RX;
          end else if (cnt_r >= TIMEOUT_LAST) begin
            state_nx  = ST_ESCAPE;
            tx_err_nx = 1'b1;
          end else begin
            state_nx = ST_XMIT;
          end
        end
        ST_RX: begin
          if (bus.read_finished) begin
            state_nx = ST_IDLE;
          end else if (cnt_r >= TIMEOUT_LAST) begin
            state_nx  = ST_ESCAPE;
            tx_err_nx = 1'b0;
          end else begin
            state_nx = ST_RX;
          end
        end
        ST_ESCAPE: begin
          if (cnt_r < ESCAPE_LEN || !bus.link_layer_ready) begin
            state_nx = ST_ESCAPE;
          end else if (tx_err_r) begin
            retry_nx = retry_inc;
            if (retry_inc > RETRY_LIMIT) begin
              state_nx    = ST_FAIL;
              err_code_nx = ERR_RETRY;
            end else begin
              state_nx = ST_BACKOFF;
            end
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_BACKOFF: begin
          if (cnt_r >= BACKOFF_LAST) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_BACKOFF;
          end
        end
        ST_DONE, ST_FAIL: begin
          state_nx = ST_IDLE;
          retry_nx = 4'd0;
        end
        default: begin
          state_nx = ST_IDLE;
          retry_nx = 4'd0;
        end
      endcase
    end
  end

  // State register and registered outputs, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      retry_r       <= 4'd0;
      tx_err_r      <= 1'b0;
      size_r        <= {SIZE_W{1'b0}};
      err_code_r    <= ERR_NONE;
      write_start_r <= 1'b0;
      sync_escape_r <= 1'b0;
      tx_grant_r    <= 1'b0;
      tx_done_r     <= 1'b0;
      tx_fail_r     <= 1'b0;
      rx_busy_r     <= 1'b0;
    end else begin
      state_r       <= state_nx;
      cnt_r         <= cnt_nx;
      retry_r       <= retry_nx;
      tx_err_r      <= tx_err_nx;
      size_r        <= size_nx;
      err_code_r    <= err_code_nx;
      write_start_r <= (state_nx == ST_START);
      sync_escape_r <= (state_nx == ST_ESCAPE) && (cnt_nx < ESCAPE_LEN);
      tx_grant_r    <= (state_nx inside {ST_START, ST_XMIT}) ||
                       (state_nx == ST_ESCAPE && tx_err_nx);
      tx_done_r     <= (state_nx == ST_DONE);
      tx_fail_r     <= (state_nx == ST_FAIL);
      rx_busy_r     <= (state_nx == ST_RX);
    end
  end

  assign bus.write_start = write_start_r;
  assign bus.write_size  = size_r;
  assign bus.sync_escape = sync_escape_r;
  assign bus.tx_grant    = tx_grant_r;
  assign bus.tx_done     = tx_done_r;
  assign bus.tx_fail     = tx_fail_r;
  assign bus.tx_err_code = err_code_r;
  assign bus.rx_busy     = rx_busy_r;
  assign bus.retry_count = retry_r;
  assign bus.arb_state   = state_r;

endmodule
